// File: rtl/ddr3_multich_burst_writer.sv
// ddr3_multich_burst_writer
//   Drains NUM_CH show-ahead write FIFOs into DDR3 with fixed-address Avalon-MM
//   write bursts. Channels are served round-robin. The last burst of a frame is
//   shortened when FRAME_WORDS is not a multiple of BURST_LEN. Each channel can
//   optionally ping-pong between two frame buffers.
//   Everything runs in the DDR3 clock domain.
// Ports
//   ddr3_clk, ddr3_clk_reset_n : clock, asynchronous active-low reset
//   ch_enable          : per-channel grant enable
//   ch_frame_restart   : per-channel pulse, restart at word 0 / buffer 0
//   ch_fifo_level      : per-channel FIFO used-words (LEVEL_W each)
//   ch_fifo_q          : per-channel FIFO head data (DATA_W each)
//   ch_fifo_rdreq      : per-channel FIFO pop
//   ddr3_write_address, ddr3_write_data, ddr3_write, ddr3_burstcount,
//   ddr3_waitrequest   : Avalon-MM burst write master
//   ch_frame_done      : per-channel pulse after the last frame word is accepted
//   ch_active_buf      : per-channel buffer index currently written
//   busy               : high while a burst is in progress
module ddr3_multich_burst_writer #(
  parameter int              NUM_CH      = 2,
  parameter int              DATA_W      = 256,
  parameter int              ADDR_W      = 27,
  parameter int              LEVEL_W     = 8,
  parameter int              BURST_LEN   = 8,
  parameter int              FRAME_WORDS = 86400,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 27'h1B00000,
  parameter logic [ADDR_W-1:0] CH_STRIDE  = 27'h0040000,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = 27'h0020000,
  parameter bit              PINGPONG    = 1'b1
) (
  input  logic                      ddr3_clk,
  input  logic                      ddr3_clk_reset_n,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH-1:0]         ch_frame_restart,
  input  logic [NUM_CH*LEVEL_W-1:0] ch_fifo_level,
  input  logic [NUM_CH*DATA_W-1:0]  ch_fifo_q,
  output logic [NUM_CH-1:0]         ch_fifo_rdreq,
  output logic [ADDR_W-1:0]         ddr3_write_address,
  output logic [DATA_W-1:0]         ddr3_write_data,
  output logic                      ddr3_write,
  output logic [7:0]                ddr3_burstcount,
  input  logic                      ddr3_waitrequest,
  output logic [NUM_CH-1:0]         ch_frame_done,
  output logic [NUM_CH-1:0]         ch_active_buf,
  output logic                      busy
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WC_W  = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_BURST} state_t;

  state_t            r_state, w_state_nxt;
  logic [WC_W-1:0]   r_wc [NUM_CH];
  logic [NUM_CH-1:0] r_buf, r_done, r_pend;
  logic [SEL_W-1:0]  r_sel, r_ptr;
  logic [7:0]        r_beat, r_bc;
  logic [ADDR_W-1:0] r_addr;

  logic [7:0]        w_need [NUM_CH];
  logic [NUM_CH-1:0] w_elig, w_frame_end, w_busy_on, w_rdreq;
  logic              w_gnt_vld, w_accept, w_last;
  logic [SEL_W-1:0]  w_gnt;
  logic [ADDR_W-1:0] w_gnt_addr;
  int                w_idx;

  // Beats still owed in the current frame, capped at one full burst.
  function automatic logic [7:0] f_need(input logic [WC_W-1:0] wc);
    int rem;
    rem = FRAME_WORDS - int'(wc);
    if (rem > BURST_LEN) return 8'(BURST_LEN);
    return 8'(rem);
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_need[c]      = f_need(r_wc[c]);
      w_elig[c]      = ch_enable[c] &&
                       (32'(ch_fifo_level[c*LEVEL_W +: LEVEL_W]) >= 32'(w_need[c]));
      w_frame_end[c] = (int'(r_wc[c]) + 1 == FRAME_WORDS);
    end
  end

  // Round-robin scan starting at r_ptr; only meaningful in ST_ARB.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!w_gnt_vld && w_elig[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = SEL_W'(w_idx);
      end
    end
    if (r_state != ST_ARB) w_gnt_vld = 1'b0;
  end

  assign w_gnt_addr = BASE_ADDR + ADDR_W'(w_gnt) * CH_STRIDE
                    + (r_buf[w_gnt] ? BUF_STRIDE : '0)
                    + ADDR_W'(r_wc[w_gnt]);

  assign w_accept = (r_state == ST_BURST) && !ddr3_waitrequest;
  assign w_last   = w_accept && (r_beat == r_bc - 8'd1);

  // A channel counts as "in a burst" from the grant cycle on, so a restart
  // arriving while the grant is registered cannot race the captured address.
  always_comb begin
    w_rdreq = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_busy_on[c] = ((r_state == ST_BURST) && (r_sel == SEL_W'(c))) ||
                     (w_gnt_vld && (w_gnt == SEL_W'(c)));
    end
    if (w_accept) w_rdreq[r_sel] = 1'b1;
  end

  always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
    if (!ddr3_clk_reset_n) r_state <= ST_IDLE;
    else                   r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_ARB;
      ST_ARB:   if (w_gnt_vld) w_state_nxt = ST_BURST;
      ST_BURST: if (w_last)    w_state_nxt = ST_ARB;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Burst command registers: captured on grant, held for the whole burst.
  always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
    if (!ddr3_clk_reset_n) begin
      r_sel  <= '0;
      r_ptr  <= '0;
      r_beat <= '0;
      r_bc   <= '0;
      r_addr <= '0;
    end else if (w_gnt_vld) begin
      r_sel  <= w_gnt;
      r_bc   <= w_need[w_gnt];
      r_addr <= w_gnt_addr;
      r_beat <= '0;
    end else if (w_accept) begin
      r_beat <= r_beat + 8'd1;
      if (w_last) r_ptr <= (r_sel == SEL_W'(NUM_CH - 1)) ? '0 : r_sel + SEL_W'(1);
    end
  end

  // Per-channel frame bookkeeping. Restart beats frame completion for the
  // buffer index, but the frame-done pulse is still reported.
  always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
    if (!ddr3_clk_reset_n) begin
      for (int c = 0; c < NUM_CH; c++) r_wc[c] <= '0;
      r_buf  <= '0;
      r_done <= '0;
      r_pend <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_done[c] <= 1'b0;
        if (w_accept && (r_sel == SEL_W'(c))) begin
          if (w_last) begin
            r_done[c] <= w_frame_end[c];
            r_pend[c] <= 1'b0;
            if (ch_frame_restart[c] || r_pend[c]) begin
              r_wc[c]  <= '0;
              r_buf[c] <= 1'b0;
            end else if (w_frame_end[c]) begin
              r_wc[c] <= '0;
              if (PINGPONG) r_buf[c] <= ~r_buf[c];
            end else begin
              r_wc[c] <= r_wc[c] + WC_W'(1);
            end
          end else begin
            r_wc[c] <= r_wc[c] + WC_W'(1);
            if (ch_frame_restart[c]) r_pend[c] <= 1'b1;
          end
        end else if (ch_frame_restart[c]) begin
          if (w_busy_on[c]) begin
            r_pend[c] <= 1'b1;
          end else begin
            r_wc[c]  <= '0;
            r_buf[c] <= 1'b0;
          end
        end
      end
    end
  end

  assign ddr3_write         = (r_state == ST_BURST);
  assign busy               = (r_state == ST_BURST);
  assign ddr3_write_address = r_addr;
  assign ddr3_burstcount    = r_bc;
  assign ddr3_write_data    = ch_fifo_q[int'(r_sel)*DATA_W +: DATA_W];
  assign ch_fifo_rdreq      = w_rdreq;
  assign ch_frame_done      = r_done;
  assign ch_active_buf      = r_buf;

endmodule
